// File: rtl/cart_bank_mapper_if.sv
// Shared mapper/cartridge-type codes and the CPU-slot / ROM-request bus
// between the slot decoder and cart_bank_mapper.

package cart_mapper_pkg;

    localparam logic [5:0] MAPPER_NONE       = 6'd0;
    localparam logic [5:0] MAPPER_LINEAR     = 6'd1;
    localparam logic [5:0] MAPPER_KONAMI     = 6'd2;
    localparam logic [5:0] MAPPER_KONAMI_SCC = 6'd3;
    localparam logic [5:0] MAPPER_ASCII8     = 6'd4;
    localparam logic [5:0] MAPPER_ASCII16    = 6'd5;
    localparam logic [5:0] MAPPER_KOEI       = 6'd6;
    localparam logic [5:0] MAPPER_WIZARDRY   = 6'd7;
    localparam logic [5:0] MAPPER_RTYPE      = 6'd8;

    localparam logic [2:0] CART_TYPE_NONE = 3'd0;
    localparam logic [2:0] CART_TYPE_ROM  = 3'd1;
    localparam logic [2:0] CART_TYPE_SCC  = 3'd2;
    localparam logic [2:0] CART_TYPE_RAM  = 3'd3;

    typedef enum logic [2:0] {
        FAM_NONE,
        FAM_LINEAR,
        FAM_KONAMI,
        FAM_SCC,
        FAM_ASCII8,
        FAM_ASCII16,
        FAM_RTYPE
    } family_t;

    // Koei and Wizardry bank exactly like ASCII8 as far as addressing goes.
    function automatic family_t mapper_family(input logic [5:0] code);
        case (code)
            MAPPER_LINEAR:     mapper_family = FAM_LINEAR;
            MAPPER_KONAMI:     mapper_family = FAM_KONAMI;
            MAPPER_KONAMI_SCC: mapper_family = FAM_SCC;
            MAPPER_ASCII8,
            MAPPER_KOEI,
            MAPPER_WIZARDRY:   mapper_family = FAM_ASCII8;
            MAPPER_ASCII16:    mapper_family = FAM_ASCII16;
            MAPPER_RTYPE:      mapper_family = FAM_RTYPE;
            default:           mapper_family = FAM_NONE;
        endcase
    endfunction

endpackage

interface cart_bank_mapper_if #(
    parameter int CHANNELS = 2,
    parameter int ROM_AW   = 21
);
    logic [CHANNELS-1:0]        slot_sel;
    logic [15:0]                cpu_addr;
    logic [7:0]                 cpu_din;
    logic                       cpu_wr;
    logic                       cpu_rd;
    logic [ROM_AW*CHANNELS-1:0] rom_addr;
    logic [CHANNELS-1:0]        rom_oe;

    modport master (
        output slot_sel, cpu_addr, cpu_din, cpu_wr, cpu_rd,
        input  rom_addr, rom_oe
    );

    modport slave (
        input  slot_sel, cpu_addr, cpu_din, cpu_wr, cpu_rd,
        output rom_addr, rom_oe
    );
endinterface

// File: rtl/cart_bank_mapper.sv
// Multi-channel cartridge bank mapper: per-slot bank registers, write decode
// and registered CPU-to-ROM address translation.

module cart_bank_mapper
    import cart_mapper_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ROM_AW   = 21,
    parameter int BANK_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [CHANNELS-1:0]        en,
    input  logic [6*CHANNELS-1:0]      mapper,
    input  logic [3*CHANNELS-1:0]      cart_type,
    input  logic [ROM_AW*CHANNELS-1:0] rom_mask,
    cart_bank_mapper_if.slave          bus
);

    logic [ROM_AW-1:0] rom_addr_ch [CHANNELS];
    logic              rom_oe_ch   [CHANNELS];

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        bus.rom_addr = '0;
        bus.rom_oe   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.rom_addr[c*ROM_AW +: ROM_AW] = rom_addr_ch[c];
            bus.rom_oe[c]                    = rom_oe_ch[c];
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [9:0]        cfg, cfg_q;
        logic [15:0]       a;
        logic [ROM_AW-1:0] mask;
        family_t           fam;
        logic              active, changed, sel_wr, sel_rd;
        logic              wr_hit;
        logic [1:0]        wr_idx;
        logic [BANK_W-1:0] wr_val;
        logic              in_window;
        logic [1:0]        rd_idx;
        logic [BANK_W-1:0] rd_bank;
        logic [ROM_AW-1:0] rd_addr;
        logic [BANK_W-1:0] bank_rst [4];
        logic [BANK_W-1:0] bank_q   [4];
        logic [ROM_AW-1:0] rom_addr_q;
        logic              rom_oe_q;

        assign a       = bus.cpu_addr;
        assign cfg     = {en[ch], cart_type[3*ch +: 3], mapper[6*ch +: 6]};
        assign mask    = rom_mask[ROM_AW*ch +: ROM_AW];
        assign fam     = mapper_family(mapper[6*ch +: 6]);
        assign active  = en[ch] && (cart_type[3*ch +: 3] == CART_TYPE_ROM) && (fam != FAM_NONE);
        assign changed = (cfg != cfg_q);
        assign sel_wr  = active && bus.cpu_wr && bus.slot_sel[ch];
        // A simultaneous write wins: the read strobe is dropped.
        assign sel_rd  = active && bus.cpu_rd && !bus.cpu_wr && bus.slot_sel[ch];

        always_comb begin
            for (int b = 0; b < 4; b++) bank_rst[b] = '0;
            if (fam == FAM_KONAMI || fam == FAM_SCC) begin
                for (int b = 0; b < 4; b++) bank_rst[b] = BANK_W'(b);
            end
            if (fam == FAM_RTYPE) bank_rst[0] = BANK_W'(8'h0F);
        end

        always_comb begin
            wr_hit = 1'b0;
            wr_idx = 2'd0;
            wr_val = BANK_W'(bus.cpu_din);
            case (fam)
                FAM_KONAMI: if (a[15:13] >= 3'd3 && a[15:13] <= 3'd5) begin
                    wr_hit = 1'b1;
                    wr_idx = 2'(a[15:13] - 3'd2);
                end
                FAM_SCC: if (a[12] && !a[11] && a[15:13] >= 3'd2 && a[15:13] <= 3'd5) begin
                    wr_hit = 1'b1;
                    wr_idx = 2'(a[15:13] - 3'd2);
                end
                FAM_ASCII8: if (a[15:13] == 3'b011) begin
                    wr_hit = 1'b1;
                    wr_idx = a[12:11];
                end
                FAM_ASCII16: if (a[15:13] == 3'b011 && !a[11]) begin
                    wr_hit = 1'b1;
                    wr_idx = {1'b0, a[12]};
                end
                FAM_RTYPE: if (a[15:12] == 4'h7) begin
                    wr_hit = 1'b1;
                    wr_idx = 2'd1;
                    wr_val = BANK_W'(bus.cpu_din & (bus.cpu_din[4] ? 8'h17 : 8'h1F));
                end
                default: ;
            endcase
        end

        // 8K pages map 4000/6000/8000/A000 onto B0..B3; 16K pages use cpu_addr[15].
        always_comb begin
            rd_idx    = 2'(a[14:13] - 2'd2);
            in_window = (a[15:14] == 2'b01) || (a[15:14] == 2'b10);
            rd_bank   = bank_q[rd_idx];
            rd_addr   = ROM_AW'({rd_bank, a[12:0]});
            case (fam)
                FAM_ASCII16, FAM_RTYPE: begin
                    rd_bank = bank_q[{1'b0, a[15]}];
                    rd_addr = ROM_AW'({rd_bank, a[13:0]});
                end
                FAM_LINEAR: begin
                    in_window = 1'b1;
                    rd_addr   = ROM_AW'(a);
                end
                default: ;
            endcase
            rd_addr = rd_addr & mask;
        end

        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        // NOTE: the bank array is mapper state with defined power-up values,
        // not storage, so it is reset like any other register.
        always_ff @(posedge clk) begin
            cfg_q    <= cfg;
            rom_oe_q <= 1'b0;
            if (!reset_n || changed) begin
                for (int b = 0; b < 4; b++) bank_q[b] <= bank_rst[b];
            end else if (sel_wr && wr_hit) begin
                bank_q[wr_idx] <= wr_val;
            end
            if (!reset_n) begin
                rom_addr_q <= '0;
            end else if (!changed && sel_rd && in_window) begin
                rom_addr_q <= rd_addr;
                rom_oe_q   <= 1'b1;
            end
        end

        assign rom_addr_ch[ch] = rom_addr_q;
        assign rom_oe_ch[ch]   = rom_oe_q;
    end

endmodule
